mmio_result_port: RTL and testbench
===================================

# mmio_result_port

Memory-mapped write sink on the data-memory bus of the single-cycle ARM core. It receives the store stream the processor drives on `MemWrite`/`DataAdr`/`WriteData` and decodes stores to one data address. Accepted words go into an in-order FIFO, which an external consumer (host, checker, UART bridge) drains through a valid/ready port. The core can poll a status word to find FIFO occupancy and overflow.

## Interface
- `BASE_ADDR`, default 32'h0000_0100: word address of the DATA register. STATUS is at `BASE_ADDR + 4`.
- `DEPTH`, default 8: number of FIFO entries. Must be a power of two, at least 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low. Low clears all state immediately.
- `MemWrite`  in  1  core store strobe, valid for the whole cycle.
- `DataAdr`  in  32  core data address.
- `WriteData`  in  32  core store data.
- `ReadData`  out  32  combinational read data for `DataAdr`. The core muxes this into its load path.
- `out_valid`  out  1  FIFO head is valid.
- `out_data`  out  32  FIFO head word (show-ahead).
- `out_ready`  in  1  consumer accepts the head when `out_valid` is also high.
- `overflow`  out  1  sticky flag: a store was dropped.

## Operation
- Push: `MemWrite && DataAdr == BASE_ADDR`. `WriteData` is written at the tail.
- Pop: `out_valid && out_ready`. The head pointer advances.
- Full, no pop: a push is dropped and `overflow` sets on the next edge. FIFO contents are unchanged.
- Full, pop in the same cycle: the push is accepted. Count stays at DEPTH.
- Empty, push: the word appears on `out_data` with `out_valid` high after that edge. No bypass: the word is never visible in the same cycle as the push.
- Push and pop together, not full: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1, range 0..DEPTH.
- Store to STATUS with `WriteData[0]` = 1 clears `overflow`. All other STATUS bits are ignored on write.
- If an overflow-causing push and the clear happen in the same cycle, set wins.
- STATUS read value: [31:16] count zero-extended, [2] overflow, [1] full, [0] empty.
- DATA read value: current head, or 0 when empty. A read never pops.
- Any other address: `ReadData` = 0, stores are ignored.

## Timing
- Reset values:
  - pointers 0, count 0;
  - `out_valid` 0, `overflow` 0;
  - `out_data` 0 while empty;
  - `ReadData` follows its combinational definition.
- Push-to-`out_valid` latency: 1 clock edge.
- `out_valid` never depends combinationally on `out_ready`.
- `out_data` is stable while `out_valid` is high and `out_ready` is low.
- `reset` asserted mid-operation discards all entries immediately, without waiting for a clock edge. Release takes effect at the first rising edge after `reset` goes high.
- `ReadData` reflects state as of the last edge. Same-cycle pushes and pops are not visible in it.

## Structure
- Package `mmio_pkg` holds:
  - `BASE_ADDR` default;
  - register offsets `OFS_DATA` = 0 and `OFS_STATUS` = 4;
  - STATUS bit positions `ST_EMPTY`, `ST_FULL`, `ST_OVF`, `ST_CNT_LSB`;
  - `typedef logic [31:0] word_t`.
- Sub-module `sync_fifo` (parameter DEPTH, word_t data) provides:
  - storage array, head/tail pointers, count;
  - push/pop handling and full/empty flags.
- The top level holds only the address decode, the STATUS/overflow logic and the read mux.

## Test plan
- **Fibonacci stream.** Core stores 1,2,3,5,8,13,21,34,55 to DATA with `out_ready` = 1. Required: `out_data` shows the same nine values in order, each 1 cycle after its store; `overflow` stays 0.
- **Fill to full.** 8 stores with `out_ready` = 0. Required: STATUS reads 32'h0008_0002. A 9th store (value 99) gives STATUS 32'h0008_0006, and 99 is never output.
- **Full with simultaneous push and pop.** FIFO full, store 77 while `out_ready` = 1. Required: the old head is consumed, count stays 8, and 77 is the last word out.
- **Overflow clear.** With `overflow` set, store 1 to STATUS. Required: STATUS bit 2 = 0 next cycle. Repeat while also overflowing in the same cycle; required: bit 2 = 1.
- **Reset mid-stream.** 3 entries queued, then `reset` pulled low between clock edges. Required: `out_valid` = 0 and STATUS = 32'h0000_0001 immediately, without a clock edge.
- **Address decode.** Store to `BASE_ADDR` + 8 and to `BASE_ADDR` − 4. Required: count is unchanged and `ReadData` = 0 for those addresses.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped result port.
package mmio_pkg;

    typedef logic [31:0] word_t;

    localparam word_t BASE_ADDR_DEFAULT = 32'h0000_0100;

    localparam word_t OFS_DATA   = 32'd0;
    localparam word_t OFS_STATUS = 32'd4;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 16;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO: the head word is visible combinationally; a full FIFO
// still accepts a push when a pop happens in the same cycle.
module sync_fifo
    import mmio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  word_t                      wdata,
    output word_t                      rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    word_t          mem [DEPTH];
    logic [PW-1:0]  head_reg, head_next;
    logic [PW-1:0]  tail_reg, tail_next;
    logic [CW-1:0]  count_reg, count_next;
    logic           push_acc;
    logic           pop_acc;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == FULL_CNT);
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);
    assign drop     = push && !push_acc;
    assign count    = count_reg;
    assign rdata    = empty ? '0 : mem[head_reg];

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (pop_acc)
            head_next = head_reg + 1'b1;
        if (push_acc)
            tail_next = tail_reg + 1'b1;
        if (push_acc && !pop_acc)
            count_next = count_reg + 1'b1;
        else if (pop_acc && !push_acc)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Storage needs no reset: reads are masked by the empty flag.
    always_ff @(posedge clk) begin
        if (push_acc)
            mem[tail_reg] <= wdata;
    end

endmodule

// File: rtl/mmio_result_port.sv
// Store sink on the core data bus: DATA pushes into a FIFO drained by a
// valid/ready consumer; STATUS reports occupancy and a sticky overflow flag.
module mmio_result_port
    import mmio_pkg::*;
#(
    parameter word_t BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int    DEPTH     = 8
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  MemWrite,
    input  word_t DataAdr,
    input  word_t WriteData,
    output word_t ReadData,
    output logic  out_valid,
    output word_t out_data,
    input  logic  out_ready,
    output logic  overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          sel_data;
    logic          sel_status;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    logic          drop;
    logic          ovf_clr;
    logic [CW-1:0] count;
    logic          overflow_reg;
    word_t         head_word;
    word_t         status_word;

    assign sel_data   = (DataAdr == BASE_ADDR + OFS_DATA);
    assign sel_status = (DataAdr == BASE_ADDR + OFS_STATUS);
    assign push       = MemWrite && sel_data;
    assign ovf_clr    = MemWrite && sel_status && WriteData[0];
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign out_data   = head_word;
    assign overflow   = overflow_reg;

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (WriteData),
        .rdata (head_word),
        .empty (empty),
        .full  (full),
        .count (count),
        .drop  (drop)
    );

    // A dropped push in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow_reg <= 1'b0;
        else if (drop)
            overflow_reg <= 1'b1;
        else if (ovf_clr)
            overflow_reg <= 1'b0;
    end

    always_comb begin
        status_word                       = '0;
        status_word[ST_CNT_LSB +: CW]     = count;
        status_word[ST_OVF]               = overflow_reg;
        status_word[ST_FULL]              = full;
        status_word[ST_EMPTY]             = empty;
    end

    always_comb begin
        ReadData = '0;
        if (sel_data)
            ReadData = head_word;
        else if (sel_status)
            ReadData = status_word;
    end

endmodule

// File: tb/tb_mmio_result_port.sv
// Directed bench for mmio_result_port: a vector table for the streaming
// case, hand-written sequences for fill, overflow, reset and decode.
module tb_mmio_result_port;

    localparam logic [31:0] DATA_A = 32'h0000_0100;
    localparam logic [31:0] STAT_A = 32'h0000_0104;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = DATA_A;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mmio_result_port dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] exp_rd;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    // One bus cycle; inputs applied 1ns after an edge, store strobe cleared after the next edge.
    task automatic cyc(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic rdy);
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = wd;
        out_ready = rdy;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic read_status(input string name, input logic [31:0] exp);
        DataAdr = STAT_A;
        #1;
        check(name, ReadData, exp);
    endtask

    initial begin
        int fib [9] = '{1, 2, 3, 5, 8, 13, 21, 34, 55};
        logic [31:0] drain [8] = '{102, 103, 104, 105, 106, 107, 108, 77};

        for (int i = 0; i < 9; i++) begin
            vecs[i] = '{we: 1'b1, adr: DATA_A, wd: 32'(fib[i]), rdy: 1'b1,
                        exp_rd: (i == 0) ? 32'd0 : 32'(fib[i-1]),
                        exp_valid: 1'b1, exp_data: 32'(fib[i]), exp_ovf: 1'b0};
        end
        vecs[9] = '{we: 1'b0, adr: DATA_A, wd: 32'd0, rdy: 1'b1, exp_rd: 32'd55,
                    exp_valid: 1'b0, exp_data: 32'd0, exp_ovf: 1'b0};

        // Reset state
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        read_status("rst_status", 32'h0000_0001);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Fibonacci stream
        for (int i = 0; i < 10; i++) begin
            MemWrite  = vecs[i].we;
            DataAdr   = vecs[i].adr;
            WriteData = vecs[i].wd;
            out_ready = vecs[i].rdy;
            #1;
            check($sformatf("fib%0d_rd", i), ReadData, vecs[i].exp_rd);
            @(posedge clk);
            #1;
            MemWrite  = 1'b0;
            out_ready = 1'b0;
            check($sformatf("fib%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("fib%0d_data", i), out_data, vecs[i].exp_data);
            check($sformatf("fib%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
        end

        // Fill to full, then one dropped store
        for (int i = 0; i < 8; i++)
            cyc(1'b1, DATA_A, 32'(101 + i), 1'b0);
        read_status("full_status", 32'h0008_0002);
        cyc(1'b1, DATA_A, 32'd99, 1'b0);
        read_status("ovf_status", 32'h0008_0006);
        check("ovf_head", out_data, 32'd101);

        // Full with push and pop together
        cyc(1'b1, DATA_A, 32'd77, 1'b1);
        read_status("full_pp_status", 32'h0008_0006);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("drain%0d_data", i), out_data, drain[i]);
            cyc(1'b0, DATA_A, 32'd0, 1'b1);
        end
        read_status("drained_status", 32'h0000_0005);

        // Overflow clear
        cyc(1'b1, STAT_A, 32'd1, 1'b0);
        read_status("clr_status", 32'h0000_0001);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, DATA_A, 32'(i), 1'b0);
        cyc(1'b1, DATA_A, 32'd200, 1'b0);
        read_status("ovf2_status", 32'h0008_0006);
        cyc(1'b1, STAT_A, 32'd2, 1'b0);
        read_status("noclr_status", 32'h0008_0006);
        cyc(1'b1, STAT_A, 32'd1, 1'b0);
        read_status("clr2_status", 32'h0008_0002);
        cyc(1'b1, DATA_A, 32'd201, 1'b0);
        read_status("reovf_status", 32'h0008_0006);

        // Reset mid-stream with 3 entries queued
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc(1'b1, DATA_A, 32'(300 + i), 1'b0);
        read_status("three_status", 32'h0003_0000);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        read_status("midrst_status", 32'h0000_0001);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Address decode
        cyc(1'b1, DATA_A, 32'd400, 1'b0);
        cyc(1'b1, DATA_A, 32'd401, 1'b0);
        cyc(1'b1, DATA_A + 32'd8, 32'd402, 1'b0);
        cyc(1'b1, DATA_A - 32'd4, 32'd403, 1'b0);
        read_status("dec_status", 32'h0002_0000);
        DataAdr = DATA_A + 32'd8;
        #1;
        check("dec_rd_p8", ReadData, 32'd0);
        DataAdr = DATA_A - 32'd4;
        #1;
        check("dec_rd_m4", ReadData, 32'd0);
        DataAdr = DATA_A;
        #1;
        check("dec_rd_data", ReadData, 32'd400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
